ccff_chain_loader: RTL and testbench

//  Configuration-chain loader for the routing tiles (cbx/cby/sb). Accepts bitstream words on a

---
 rtl/ccff_chain_loader.sv | 99 +++++++++
 tb/tb_ccff_chain_loader.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: takes bitstream words on a valid/ready stream and
// shifts exactly CHAIN_LEN bits LSB-first onto ccff_head with a gated chain clock.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 58,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int BIDX_W = $clog2(WORD_W);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state, state_next;
  logic [WORD_W-1:0]   wreg;
  logic                wvalid;
  logic [BIDX_W-1:0]   bit_idx;
  logic [CNT_W-1:0]    shift_cnt;
  logic                in_shift, last_bit, last_chain, shift, load, begin_load;

  // Ready is allowed on the last bit of a word so the next word lands without a bubble.
  always_comb begin
    in_shift   = (state == SHIFT);
    last_bit   = (bit_idx == BIDX_W'(WORD_W - 1));
    last_chain = (shift_cnt == CNT_W'(CHAIN_LEN - 1));
    shift      = in_shift & wvalid & ~abort;
    s_ready    = in_shift & (~wvalid | (last_bit & ~last_chain));
    load       = s_valid & s_ready & ~abort;
    begin_load = start & (((state == IDLE) & ~abort) | (state == DONE));
  end

  assign ccff_shift_en = shift;
  assign ccff_head     = wreg[0];
  assign busy          = in_shift;
  assign done          = (state == DONE);

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (begin_load) state_next = SHIFT;
      SHIFT: begin
        if (abort)                     state_next = IDLE;
        else if (shift && last_chain)  state_next = DONE;
      end
      DONE:    if (begin_load) state_next = SHIFT;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      wreg      <= '0;
      wvalid    <= 1'b0;
      bit_idx   <= '0;
      shift_cnt <= '0;
      err       <= 1'b0;
    end else if (begin_load) begin
      wvalid    <= 1'b0;
      bit_idx   <= '0;
      shift_cnt <= '0;
      err       <= 1'b0;
    end else if (in_shift) begin
      if (abort) begin
        wvalid <= 1'b0;
        err    <= 1'b1;
      end else begin
        if (shift) shift_cnt <= shift_cnt + CNT_W'(1);
        if (load) begin
          wreg    <= s_data;
          wvalid  <= 1'b1;
          bit_idx <= '0;
        end else if (shift) begin
          wreg    <= wreg >> 1;
          bit_idx <= bit_idx + BIDX_W'(1);
          // The tail of the final word is dropped once the chain is full.
          if (last_bit || last_chain) wvalid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboarded bench for ccff_chain_loader: expected bit stream and final chain image
// are derived from the words offered; a monitor checks every chain shift.
module tb_ccff_chain_loader;
  localparam int L  = 58;
  localparam int W  = 8;
  localparam int NW = (L + W - 1) / W;

  typedef logic [W-1:0] words_t [NW];

  logic         prog_clk, pReset, start, abort, s_valid;
  logic [W-1:0] s_data;
  logic         s_ready, ccff_head, ccff_shift_en, busy, done, err;

  int           compared = 0;
  int           mismatched = 0;
  int           shift_total = 0;
  bit           exp_q[$];
  logic [L-1:0] chain = '0;

  ccff_chain_loader #(.CHAIN_LEN(L), .WORD_W(W)) dut (
    .prog_clk(prog_clk), .pReset(pReset), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en),
    .busy(busy), .done(done), .err(err)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Chain model: index 0 is the head flip-flop, index L-1 feeds ccff_tail.
  always @(negedge prog_clk) begin
    if (ccff_shift_en === 1'b1) begin
      shift_total++;
      chain = {chain[L-2:0], ccff_head};
      if (exp_q.size() == 0) check("unexpected_shift", 64'(ccff_shift_en), 64'(0));
      else check("head_bit", 64'(ccff_head), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Caller must be positioned just after a rising edge.
  task automatic run_load(input words_t w, input int stall, input int abort_at,
                          input int rst_at, input int start_at);
    logic [L-1:0] exp_chain;
    int base, wi, gap, cyc, gaps, cnt, prev;
    exp_q.delete();
    for (int k = 0; k < L; k++) begin
      exp_q.push_back(w[k / W][k % W]);
      exp_chain[L-1-k] = w[k / W][k % W];
    end
    base  = shift_total;
    start = 1'b1;
    @(posedge prog_clk); #1;
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'(1));
    check("err_cleared_by_start", 64'(err), 64'(0));
    wi = 0; gap = 0; cyc = 0; gaps = 0; prev = 0;
    while (!done && cyc < 2000) begin
      cnt   = shift_total - base;
      abort = (abort_at >= 0 && cnt == abort_at);
      start = (start_at >= 0 && cnt == start_at);
      if (gap > 0) begin
        s_valid = 1'b0;
        gap--;
      end else begin
        s_valid = (wi < NW);
        s_data  = (wi < NW) ? w[wi] : '0;
      end
      if (rst_at >= 0 && cnt == rst_at) begin
        #2 pReset = 1'b0;
        #1;
        check("reset_outputs_zero",
              64'({s_ready, ccff_head, ccff_shift_en, busy, done, err}), 64'(0));
        check("reset_shift_count", 64'(cnt), 64'(rst_at));
        s_valid = 1'b0; abort = 1'b0; start = 1'b0;
        exp_q.delete();
        @(negedge prog_clk); #1;
        pReset = 1'b1;
        @(posedge prog_clk); #1;
        check("idle_after_reset", 64'({busy, done, s_ready}), 64'(0));
        return;
      end
      @(negedge prog_clk); #1;
      if (abort) check("shift_suppressed_on_abort", 64'(ccff_shift_en), 64'(0));
      if (s_valid && s_ready) begin
        wi++;
        gap = stall;
      end
      if (shift_total - base == prev && prev > 0 && prev < L) gaps++;
      prev = shift_total - base;
      @(posedge prog_clk); #1;
      cyc++;
      if (abort) begin
        abort = 1'b0; s_valid = 1'b0; start = 1'b0;
        check("abort_to_idle", 64'({busy, done, s_ready}), 64'(0));
        check("abort_sets_err", 64'(err), 64'(1));
        check("abort_shift_count", 64'(shift_total - base), 64'(abort_at));
        exp_q.delete();
        return;
      end
      if (shift_total - base >= L) begin
        check("done_after_last_shift", 64'(done), 64'(1));
        break;
      end
    end
    s_valid = 1'b0; start = 1'b0;
    check("done_reached", 64'(done), 64'(1));
    check("shift_count", 64'(shift_total - base), 64'(L));
    check("words_accepted", 64'(wi), 64'(NW));
    check("chain_contents", 64'(chain), 64'(exp_chain));
    check("idle_ready_in_done", 64'({s_ready, busy, ccff_shift_en}), 64'(0));
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    if (stall == 0) check("no_shift_gap", 64'(gaps), 64'(0));
  endtask

  initial begin
    words_t w;
    pReset = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;

    // Reset held with toggling inputs
    for (int i = 0; i < 6; i++) begin
      @(posedge prog_clk); #1;
      start = 1'($urandom); abort = 1'($urandom);
      s_valid = 1'($urandom); s_data = W'($urandom);
      @(negedge prog_clk); #1;
      check("in_reset_outputs",
            64'({s_ready, ccff_head, ccff_shift_en, busy, done, err}), 64'(0));
    end
    start = 1'b0; abort = 1'b0; s_valid = 1'b0;
    pReset = 1'b1;
    @(posedge prog_clk); #1;
    check("idle_after_release", 64'({s_ready, busy, done, err}), 64'(0));

    // Streaming and stalled loads of words 0x01..0x08
    for (int i = 0; i < NW; i++) w[i] = W'(i + 1);
    run_load(w, 0, -1, -1, -1);
    run_load(w, 3, -1, -1, -1);

    // Abort at 20 shifts, then start+abort in IDLE, then a clean reload
    for (int i = 0; i < NW; i++) w[i] = W'($urandom);
    run_load(w, 0, 20, -1, -1);
    start = 1'b1; abort = 1'b1;
    @(posedge prog_clk); #1;
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle_busy", 64'(busy), 64'(0));
    check("start_abort_idle_err", 64'(err), 64'(1));
    run_load(w, 0, -1, -1, -1);

    // Start during SHIFT ignored; start from DONE reloads
    for (int i = 0; i < NW; i++) w[i] = W'($urandom);
    run_load(w, 1, -1, -1, 10);
    for (int i = 0; i < NW; i++) w[i] = W'($urandom);
    run_load(w, 0, -1, -1, -1);

    // Asynchronous reset mid-load, then a fresh load
    run_load(w, 1, -1, 30, -1);
    for (int i = 0; i < NW; i++) w[i] = W'($urandom);
    run_load(w, 0, -1, -1, -1);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NW; i++) w[i] = W'($urandom);
      run_load(w, int'($urandom_range(0, 2)), -1, -1, -1);
    end

    repeat (2) @(posedge prog_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
